// File: rtl/record_buffer_ctrl.sv
// Pre/post-trigger capture into a circular sample RAM, then oldest-first readout.
// One word per ReadNext, returned one cycle later.
module record_buffer_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Armed,
    input  logic              EnableRecording,
    input  logic [DATA_W-1:0] SampleIn,
    input  logic              SampleValid,
    input  logic [ADDR_W-1:0] PostCount,
    input  logic              ReadNext,
    output logic [DATA_W-1:0] ReadData,
    output logic              ReadValid,
    output logic              ReadLast,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W-1:0] TriggerAddr,
    output logic [ADDR_W:0]   WordCount
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {StIdle, StFill, StPost, StDone} state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] remaining_q, remaining_d;
    logic [ADDR_W-1:0] trigger_addr_q, trigger_addr_d;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W:0]   word_count_q, rd_count_q;
    logic              wrapped_q, wrapped_d;
    logic              wr_en, rd_en, enter_done;
    logic [DATA_W-1:0] read_data_q;
    logic              read_valid_q, read_last_q;

    logic [DATA_W-1:0] mem [DEPTH];

    always_comb begin
        state_d        = state_q;
        wr_addr_d      = wr_addr_q;
        wrapped_d      = wrapped_q;
        remaining_d    = remaining_q;
        trigger_addr_d = trigger_addr_q;
        wr_en          = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (Armed) begin
                    state_d   = StFill;
                    wr_addr_d = '0;
                    wrapped_d = 1'b0;
                end
            end
            StFill: begin
                wr_en = SampleValid;
                if (EnableRecording) begin
                    state_d     = StPost;
                    remaining_d = PostCount;
                end else if (!Armed) begin
                    state_d = StIdle;
                end
            end
            StPost: begin
                if (remaining_q == '0) begin
                    state_d = StDone;
                end else if (SampleValid) begin
                    wr_en       = 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == ADDR_W'(1)) state_d = StDone;
                end
            end
            StDone: ;
            default: state_d = StIdle;
        endcase
        if (wr_en) begin
            wr_addr_d = wr_addr_q + 1'b1;
            if (&wr_addr_q) wrapped_d = 1'b1;
        end
        // Trigger address points just past the sample written on the trigger cycle
        if (state_q == StFill && EnableRecording) trigger_addr_d = wr_addr_d;
    end

    assign enter_done = (state_q == StPost) && (state_d == StDone);
    assign rd_en      = (state_q == StDone) && ReadNext && (rd_count_q < word_count_q);

    always_ff @(posedge Clock) begin
        if (Reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_addr_q      <= '0;
            wrapped_q      <= 1'b0;
            remaining_q    <= '0;
            trigger_addr_q <= '0;
            rd_addr_q      <= '0;
            rd_count_q     <= '0;
            word_count_q   <= '0;
            read_data_q    <= '0;
            read_valid_q   <= 1'b0;
            read_last_q    <= 1'b0;
        end else begin
            wr_addr_q      <= wr_addr_d;
            wrapped_q      <= wrapped_d;
            remaining_q    <= remaining_d;
            trigger_addr_q <= trigger_addr_d;
            read_valid_q   <= rd_en;
            read_last_q    <= rd_en && ((rd_count_q + 1'b1) == word_count_q);
            if (enter_done) begin
                rd_count_q <= '0;
                if (wrapped_d) begin
                    rd_addr_q    <= wr_addr_d;
                    word_count_q <= (ADDR_W + 1)'(DEPTH);
                end else begin
                    rd_addr_q    <= '0;
                    word_count_q <= {1'b0, wr_addr_d};
                end
            end else if (rd_en) begin
                read_data_q <= mem[rd_addr_q];
                rd_addr_q   <= rd_addr_q + 1'b1;
                rd_count_q  <= rd_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (wr_en && !Reset) mem[wr_addr_q] <= SampleIn;
    end

    assign ReadData    = read_data_q;
    assign ReadValid   = read_valid_q;
    assign ReadLast    = read_last_q;
    assign Busy        = (state_q == StFill) || (state_q == StPost);
    assign Done        = (state_q == StDone);
    assign TriggerAddr = trigger_addr_q;
    assign WordCount   = word_count_q;

endmodule
